fifo_wr_arbiter: RTL
====================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin, packet-locking arbiter that shares the single write port of the 8-deep
//  sync FIFO among NREQ requesters. Selects one requester and forwards its beats to
//  fifo_wr/fifo_wdata. Holds the grant until a beat marked last is accepted.
//  Applies back-pressure from fifo_full, aborts stalled packets on a timeout, and counts
//  completed packets. Sits between producer blocks and the FIFO write side.
// PARAMETERS
//  NREQ         4    number of requesters (2..8)
//  DW           8    data width; matches FIFO data_in
//  LOCK_TIMEOUT 15   consecutive idle-owner cycles in LOCK before abort (1..255)
// PORTS
//  clk          in   1            rising-edge clock
//  rst_n        in   1            asynchronous, active-low reset
//  req          in   NREQ         req[i]=1: requester i presents a valid beat
//  last         in   NREQ         last[i]=1: requester i's beat is end of packet
//  req_data     in   NREQ*DW      requester i data at [i*DW +: DW]
//  fifo_full    in   1            FIFO full flag
//  ack          out  NREQ         one-hot; beat of requester i accepted this cycle
//  fifo_wr      out  1            FIFO write strobe
//  fifo_wdata   out  DW           FIFO write data
//  gnt_id       out  clog2(NREQ)  current/last owner index (registered)
//  busy         out  1            1 while in LOCK
//  err_timeout  out  1            one-cycle pulse on packet abort
//  pkt_cnt      out  16           completed packets, wraps 0xFFFF->0
// BEHAVIOUR
//  - Registered state: fsm {IDLE, LOCK}, rr_ptr, gnt_id, idle_cnt[7:0], pkt_cnt, err_timeout.
//  - Reset (rst_n=0, immediate): fsm=IDLE, rr_ptr=NREQ-1, gnt_id=0, idle_cnt=0, pkt_cnt=0.
//    err_timeout=0. Comb outputs ack=0, fifo_wr=0, fifo_wdata=0 for as long as rst_n=0.
//  - Comb outputs, zero latency. fifo_wr=1 iff a beat transfers this cycle.
//    ack=onehot(winner) on a transfer, else 0. fifo_wdata=winner data when fifo_wr, else 0.
//  - Never writes while fifo_full=1: no transfer, no ack, no state change except idle_cnt.
//  - IDLE: if fifo_full=0 and any req, winner = first set req scanning
//    rr_ptr+1, rr_ptr+2, ... mod NREQ. The winner's beat transfers this cycle.
//    gnt_id<=winner. If last[winner]: stay IDLE, rr_ptr<=winner, pkt_cnt++.
//    Otherwise go to LOCK with idle_cnt<=0.
//    With fifo_full=1 or no req: no decision, rr_ptr unchanged.
//  - LOCK: only gnt_id is served; other req are ignored.
//    Transfer when req[gnt_id] && !fifo_full; idle_cnt<=0 on a transfer.
//    Transfer with last: go to IDLE, rr_ptr<=gnt_id, pkt_cnt++.
//    Cycle without a transfer because req[gnt_id]=0: idle_cnt++.
//    Stall due to fifo_full does not count toward the timeout.
//    When idle_cnt reaches LOCK_TIMEOUT-1 and another idle cycle occurs:
//    err_timeout<=1 (next cycle, one pulse), go to IDLE, rr_ptr<=gnt_id, pkt_cnt unchanged.
//  - busy = (fsm==LOCK). last is ignored when req is 0.
//  - A requester must hold req/data stable until ack. Beats never duplicate or drop.
// TESTING
//  1. All 4 req set, single-beat packets (last=1), fifo_full=0 after reset.
//     -> ack order 0,1,2,3,0; one fifo_wr per cycle; pkt_cnt=5 after 5 cycles.
//  2. req1 sends 3-beat packet (0xA1,0xA2,0xA3+last) while req2 is held high.
//     -> fifo_wdata A1,A2,A3 on consecutive cycles, then req2's beat; busy=1 for beats 2-3.
//  3. Mid-packet fifo_full=1 for 3 cycles.
//     -> fifo_wr=0 and ack=0 for those cycles; same owner resumes; no timeout; idle_cnt=0.
//  4. Owner drops req after beat 1 of a packet.
//     -> err_timeout pulses once after 15 idle cycles; busy=0; pkt_cnt unchanged;
//        next arbitration starts at owner+1.
//  5. rst_n pulsed low mid-LOCK.
//     -> outputs 0 immediately; after release req0 and req3 single beats -> req0 first.
//  6. req1 only, fifo_full=1 in IDLE for 4 cycles, then 0.
//     -> no ack while full; first ack to req1 the cycle full drops; rr_ptr=1 afterwards.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locking arbiter sharing one FIFO write port among NREQ requesters.
// Owner keeps the port until its last beat is written or it goes idle for LOCK_TIMEOUT cycles.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned DW           = 8,
  parameter int unsigned LOCK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          last,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic                     fifo_full,
  output logic [NREQ-1:0]          ack,
  output logic                     fifo_wr,
  output logic [DW-1:0]            fifo_wdata,
  output logic [$clog2(NREQ)-1:0]  gnt_id,
  output logic                     busy,
  output logic                     err_timeout,
  output logic [15:0]              pkt_cnt
);

  localparam int unsigned IW = $clog2(NREQ);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [7:0]      idle_cnt;

  logic [IW-1:0]   win;
  logic            win_found;
  logic [IW-1:0]   sel;
  logic            xfer;
  logic            sel_last;

  // Round-robin search starting just after the previous owner
  always_comb begin
    logic [IW-1:0] idx;
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IW'((32'(rr_ptr) + i) % NREQ);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  // Transfer qualification; all write-side outputs forced low during reset
  always_comb begin
    sel      = (state == IDLE) ? win : gnt_id;
    xfer     = 1'b0;
    if (rst_n && !fifo_full) begin
      if (state == IDLE) xfer = win_found;
      else               xfer = req[gnt_id];
    end
    sel_last   = last[sel];
    fifo_wr    = xfer;
    ack        = xfer ? (NREQ'(1) << sel) : '0;
    fifo_wdata = xfer ? req_data[DW*32'(sel) +: DW] : '0;
  end

  assign busy = (state == LOCK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= IW'(NREQ - 1);
      gnt_id      <= '0;
      idle_cnt    <= '0;
      pkt_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer) begin
            gnt_id <= sel;
            if (sel_last) begin
              rr_ptr  <= sel;
              pkt_cnt <= pkt_cnt + 16'd1;
            end else begin
              state    <= LOCK;
              idle_cnt <= '0;
            end
          end
        end
        LOCK: begin
          if (xfer) begin
            idle_cnt <= '0;
            if (sel_last) begin
              state   <= IDLE;
              rr_ptr  <= gnt_id;
              pkt_cnt <= pkt_cnt + 16'd1;
            end
          end else if (!req[gnt_id]) begin
            // Owner idle; a fifo_full stall with req held does not count
            if (idle_cnt == 8'(LOCK_TIMEOUT - 1)) begin
              err_timeout <= 1'b1;
              state       <= IDLE;
              rr_ptr      <= gnt_id;
              idle_cnt    <= '0;
            end else begin
              idle_cnt <= idle_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
